gpfc_pause_ctrl: RTL and testbench
==================================

Name: gpfc_pause_ctrl

Overview:
Parametrised successor to the per-port congestion monitor for GPFC (generalised PFC) pause generation.
- Tracks a hysteresis congestion FSM for each of PORT_NUM queues, taken from one flat occupancy bus.
- Reduces the per-port states to one aggregate state, which drives pause/resume messages.
- Messages leave on a registered valid/ready interface, with periodic pause refresh so the upstream pause never lapses.
- Sits between the output-queue occupancy taps and the pause-frame builder in the scheduler datapath.

Parameters:
PORT_NUM, 8, number of monitored ports (1..32)
QUEUE_OCCUPANCY_UNIT_WIDTH, 12, width of each occupancy value and threshold
PAUSE_RANK_WIDTH, 16, width of the pause rank field
PAUSE_TIME_WIDTH, 16, width of the pause time field
PAUSE_TIME_VALUE_DEFAULT, 65535, pause time carried by XOFF messages
REFRESH_PERIOD, 32768, cycles between refresh re-emissions while congested (>=4)
REFRESH_CNT_WIDTH, 16, refresh counter width; must satisfy 2^REFRESH_CNT_WIDTH >= REFRESH_PERIOD

Ports:
clk  in  1  single clock
rstn  in  1  asynchronous active-low reset
s_axis_queue_occupancy  in  PORT_NUM*QUEUE_OCCUPANCY_UNIT_WIDTH  port p at bits [p*W +: W]
s_axis_port_enable  in  PORT_NUM  1 = port monitored; 0 = port forced to XON
s_axis_xoff_low  in  QUEUE_OCCUPANCY_UNIT_WIDTH  enter-XOFFLOW threshold
s_axis_xon_low  in  QUEUE_OCCUPANCY_UNIT_WIDTH  return-to-XON threshold
s_axis_xoff_all  in  QUEUE_OCCUPANCY_UNIT_WIDTH  enter-XOFFALL threshold
s_axis_xon_all  in  QUEUE_OCCUPANCY_UNIT_WIDTH  leave-XOFFALL threshold
s_axis_xoff_rank  in  PAUSE_RANK_WIDTH  rank carried by XOFFLOW messages
m_axis_valid  out  1  pending message
m_axis_ready  in  1  consumer accepts the message
m_axis_pause_rank  out  PAUSE_RANK_WIDTH  message rank; 0 = all ranks
m_axis_pause_time  out  PAUSE_TIME_WIDTH  message pause time; 0 = resume
m_axis_congestion_state  out  2  registered aggregate state
m_axis_congested_ports  out  PORT_NUM  bit p = 1 when port p is not in XON

Behaviour:
- Encoding: XON=0, XOFFLOW=1, XOFFALL=2. All compares are unsigned; "reaches" means >= and "below" means <.
- Per-port FSM, updated every cycle:
  - XON: occ >= xoff_all -> XOFFALL; else occ >= xoff_low -> XOFFLOW.
  - XOFFLOW: occ >= xoff_all -> XOFFALL; else occ < xon_low -> XON.
  - XOFFALL: occ < xon_all -> (occ < xon_low ? XON : XOFFLOW); otherwise stay.
  - Port disabled -> next state is XON. No message is generated for that port; only the aggregate is affected.
- Aggregate: registered maximum of all per-port states. m_axis_congestion_state and m_axis_congested_ports are registered.
- Latency: occupancy sampled at edge N updates the port state at N. The aggregate updates at edge N+1. m_axis_valid rises after edge N+1, i.e. 2 cycles input-to-valid.
- Message on aggregate change (old != new):
  - new XOFFLOW: rank = xoff_rank, time = DEFAULT.
  - new XOFFALL: rank = 0, time = DEFAULT.
  - new XON: rank = 0, time = 0.
- Handshake:
  - Transfer occurs when valid & ready.
  - While valid=1 and ready=0, rank and time hold stable unless a newer message arrives. A newer message overwrites the pending one (coalesce: only the latest state matters) and valid stays 1.
  - If a transfer and a new message occur in the same cycle, the new message loads and valid stays 1.
- Refresh:
  - The counter runs only while aggregate != XON and valid = 0.
  - When the counter reaches REFRESH_PERIOD-1, the message for the current aggregate state is re-emitted and the counter clears.
  - The counter clears on any aggregate change, on aggregate XON, and on reset.
  - If an aggregate change and a refresh expiry coincide, the change wins and only one message is emitted.
- Threshold inputs may change at any time; they take effect on the next compare. Threshold ordering is not checked; the FSM priority above is authoritative.
- Reset (async assert, sync-safe deassert):
  - All port states, aggregate, congested_ports and congestion_state = 0.
  - valid = 0, rank = 0, time = 0, refresh counter = 0.
  - Reset mid-operation drops any pending message. No resume message is emitted after reset.

Test Plan:
- Thresholds xon_low=100, xoff_low=200, xon_all=300, xoff_all=400, rank=5, ready=1. Port 3 occupancy 0 -> 250 -> one message {rank 5, time 65535} 2 cycles later; congested_ports = 0x08, state = 1.
- Port 3 occupancy 250 -> 450, then 450 -> 350 -> message {0, 65535} on entering XOFFALL. Nothing further at 350 (stays XOFFALL). Occupancy 80 -> message {0, 0}, state = 0.
- Port 1 at 250 and port 6 at 450 -> aggregate 2. Port 6 drops to 250 -> message {5, 65535}. Disable port 1 with port 6 at 50 -> message {0, 0}.
- ready=0; port 0 steps 250 then 450 on consecutive cycles -> valid stays high with {0, 65535} (coalesced). Raise ready -> exactly one transfer.
- REFRESH_PERIOD=16, port 2 held at 250, ready=1 -> initial message, then identical {5, 65535} every 16 cycles. Occupancy 50 -> {0, 0}, refresh stops.
- Assert rstn low while valid=1 and ready=0 -> valid = 0 and all outputs 0 immediately, without waiting for a clock edge. After release with all occupancies 0 -> no message.

Source files
------------

// File: rtl/gpfc_pause_ctrl.sv
// GPFC pause controller: per-port hysteresis congestion FSMs reduced to one aggregate
// state, which drives registered pause/resume messages with periodic pause refresh.
module gpfc_pause_ctrl #(
    parameter int PORT_NUM                   = 8,
    parameter int QUEUE_OCCUPANCY_UNIT_WIDTH = 12,
    parameter int PAUSE_RANK_WIDTH           = 16,
    parameter int PAUSE_TIME_WIDTH           = 16,
    parameter int PAUSE_TIME_VALUE_DEFAULT   = 65535,
    parameter int REFRESH_PERIOD             = 32768,
    parameter int REFRESH_CNT_WIDTH          = 16
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic [PORT_NUM*QUEUE_OCCUPANCY_UNIT_WIDTH-1:0] s_axis_queue_occupancy,
    input  logic [PORT_NUM-1:0]                            s_axis_port_enable,
    input  logic [QUEUE_OCCUPANCY_UNIT_WIDTH-1:0]          s_axis_xoff_low,
    input  logic [QUEUE_OCCUPANCY_UNIT_WIDTH-1:0]          s_axis_xon_low,
    input  logic [QUEUE_OCCUPANCY_UNIT_WIDTH-1:0]          s_axis_xoff_all,
    input  logic [QUEUE_OCCUPANCY_UNIT_WIDTH-1:0]          s_axis_xon_all,
    input  logic [PAUSE_RANK_WIDTH-1:0]                    s_axis_xoff_rank,
    output logic                                           m_axis_valid,
    input  logic                                           m_axis_ready,
    output logic [PAUSE_RANK_WIDTH-1:0]                    m_axis_pause_rank,
    output logic [PAUSE_TIME_WIDTH-1:0]                    m_axis_pause_time,
    output logic [1:0]                                     m_axis_congestion_state,
    output logic [PORT_NUM-1:0]                            m_axis_congested_ports
);

    localparam int QW = QUEUE_OCCUPANCY_UNIT_WIDTH;
    localparam logic [REFRESH_CNT_WIDTH-1:0] REFRESH_LAST    = REFRESH_CNT_WIDTH'(REFRESH_PERIOD - 1);
    localparam logic [PAUSE_TIME_WIDTH-1:0]  PAUSE_TIME_XOFF = PAUSE_TIME_WIDTH'(PAUSE_TIME_VALUE_DEFAULT);

    typedef enum logic [1:0] {
        ST_XON     = 2'd0,
        ST_XOFFLOW = 2'd1,
        ST_XOFFALL = 2'd2
    } cong_state_e;

    function automatic logic [PAUSE_RANK_WIDTH-1:0] msg_rank(input cong_state_e st,
                                                            input logic [PAUSE_RANK_WIDTH-1:0] xoff_rank);
        case (st)
            ST_XOFFLOW: msg_rank = xoff_rank;
            default:    msg_rank = {PAUSE_RANK_WIDTH{1'b0}};
        endcase
    endfunction

    function automatic logic [PAUSE_TIME_WIDTH-1:0] msg_time(input cong_state_e st);
        case (st)
            ST_XON:  msg_time = {PAUSE_TIME_WIDTH{1'b0}};
            default: msg_time = PAUSE_TIME_XOFF;
        endcase
    endfunction

    logic [QW-1:0]                  w_occ [PORT_NUM];
    cong_state_e                    r_port_state [PORT_NUM];
    cong_state_e                    w_port_next [PORT_NUM];
    cong_state_e                    r_agg;
    cong_state_e                    w_agg_next;
    cong_state_e                    w_msg_state;
    logic [PORT_NUM-1:0]            r_congested;
    logic [PORT_NUM-1:0]            w_congested_next;
    logic                           r_valid;
    logic [PAUSE_RANK_WIDTH-1:0]    r_rank;
    logic [PAUSE_TIME_WIDTH-1:0]    r_time;
    logic [REFRESH_CNT_WIDTH-1:0]   r_refresh_cnt;
    logic                           w_change;
    logic                           w_expire;

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_occ
        assign w_occ[g] = s_axis_queue_occupancy[g*QW +: QW];
    end

    // Per-port hysteresis next state; XOFFALL exit may fall straight through to XON.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            w_port_next[p] = ST_XON;
            if (!s_axis_port_enable[p]) begin
                w_port_next[p] = ST_XON;
            end else begin
                case (r_port_state[p])
                    ST_XON: begin
                        if (w_occ[p] >= s_axis_xoff_all)      w_port_next[p] = ST_XOFFALL;
                        else if (w_occ[p] >= s_axis_xoff_low) w_port_next[p] = ST_XOFFLOW;
                        else                                  w_port_next[p] = ST_XON;
                    end
                    ST_XOFFLOW: begin
                        if (w_occ[p] >= s_axis_xoff_all)     w_port_next[p] = ST_XOFFALL;
                        else if (w_occ[p] < s_axis_xon_low)  w_port_next[p] = ST_XON;
                        else                                 w_port_next[p] = ST_XOFFLOW;
                    end
                    ST_XOFFALL: begin
                        if (w_occ[p] < s_axis_xon_all)
                            w_port_next[p] = (w_occ[p] < s_axis_xon_low) ? ST_XON : ST_XOFFLOW;
                        else
                            w_port_next[p] = ST_XOFFALL;
                    end
                    default: w_port_next[p] = ST_XON;
                endcase
            end
        end
    end

    // Per-port state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < PORT_NUM; p++) r_port_state[p] <= ST_XON;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) r_port_state[p] <= w_port_next[p];
        end
    end

    // Aggregate is the worst port state; a change outranks a coincident refresh expiry.
    always_comb begin
        w_agg_next       = ST_XON;
        w_congested_next = {PORT_NUM{1'b0}};
        for (int p = 0; p < PORT_NUM; p++) begin
            if (r_port_state[p] > w_agg_next) w_agg_next = r_port_state[p];
            w_congested_next[p] = (r_port_state[p] != ST_XON);
        end
        w_change    = (w_agg_next != r_agg);
        w_expire    = (r_agg != ST_XON) && !r_valid && (r_refresh_cnt == REFRESH_LAST);
        w_msg_state = w_change ? w_agg_next : r_agg;
    end

    // Aggregate state, message slot and valid/ready handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_agg       <= ST_XON;
            r_congested <= {PORT_NUM{1'b0}};
            r_valid     <= 1'b0;
            r_rank      <= {PAUSE_RANK_WIDTH{1'b0}};
            r_time      <= {PAUSE_TIME_WIDTH{1'b0}};
        end else begin
            r_agg       <= w_agg_next;
            r_congested <= w_congested_next;
            if (w_change || w_expire) begin
                r_valid <= 1'b1;
                r_rank  <= msg_rank(w_msg_state, s_axis_xoff_rank);
                r_time  <= msg_time(w_msg_state);
            end else if (r_valid && m_axis_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Refresh timer only advances while congested with no message outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_refresh_cnt <= {REFRESH_CNT_WIDTH{1'b0}};
        end else if (w_change || (r_agg == ST_XON) || w_expire) begin
            r_refresh_cnt <= {REFRESH_CNT_WIDTH{1'b0}};
        end else if (!r_valid) begin
            r_refresh_cnt <= r_refresh_cnt + REFRESH_CNT_WIDTH'(1);
        end
    end

    assign m_axis_valid            = r_valid;
    assign m_axis_pause_rank       = r_rank;
    assign m_axis_pause_time       = r_time;
    assign m_axis_congestion_state = r_agg;
    assign m_axis_congested_ports  = r_congested;

endmodule

// File: tb/tb_gpfc_pause_ctrl.sv
// Directed self-checking bench for gpfc_pause_ctrl (8 ports, 12-bit occupancy, refresh period 16).
module tb_gpfc_pause_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [95:0] occ;
    logic [7:0]  en;
    logic [11:0] xoff_low, xon_low, xoff_all, xon_all;
    logic [15:0] xoff_rank;
    logic        valid, ready;
    logic [15:0] rank, ptime;
    logic [1:0]  cstate;
    logic [7:0]  cports;

    int total = 0;
    int bad   = 0;
    logic [42:0] exp_full;
    logic [10:0] exp_ctl;

    gpfc_pause_ctrl #(
        .PORT_NUM(8), .QUEUE_OCCUPANCY_UNIT_WIDTH(12), .PAUSE_RANK_WIDTH(16),
        .PAUSE_TIME_WIDTH(16), .PAUSE_TIME_VALUE_DEFAULT(65535),
        .REFRESH_PERIOD(16), .REFRESH_CNT_WIDTH(5)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_queue_occupancy(occ), .s_axis_port_enable(en),
        .s_axis_xoff_low(xoff_low), .s_axis_xon_low(xon_low),
        .s_axis_xoff_all(xoff_all), .s_axis_xon_all(xon_all),
        .s_axis_xoff_rank(xoff_rank),
        .m_axis_valid(valid), .m_axis_ready(ready),
        .m_axis_pause_rank(rank), .m_axis_pause_time(ptime),
        .m_axis_congestion_state(cstate), .m_axis_congested_ports(cports)
    );

    always #5 clk = ~clk;

    function automatic logic [42:0] obs_full();
        return {valid, rank, ptime, cstate, cports};
    endfunction

    function automatic logic [10:0] obs_ctl();
        return {valid, cstate, cports};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_occ(input int p, input int v);
        occ[p*12 +: 12] = 12'(v);
    endtask

    task automatic test_reset();
        occ = 96'd0; en = 8'hFF; ready = 1'b1;
        xon_low = 12'd100; xoff_low = 12'd200; xon_all = 12'd300; xoff_all = 12'd400;
        xoff_rank = 16'd5;
        repeat (2) tick();
        exp_full = 43'd0;
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL reset_state: got %h want %h", obs_full(), exp_full); end
        rstn = 1'b1;
        repeat (3) tick();
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL idle_after_reset: got %h want %h", obs_full(), exp_full); end
    endtask

    task automatic test_xoff_low();
        set_occ(3, 250);
        tick();
        exp_ctl = 11'd0;
        total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL xofflow_latency: got %h want %h", obs_ctl(), exp_ctl); end
        tick();
        exp_full = {1'b1, 16'd5, 16'hFFFF, 2'd1, 8'h08};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL xofflow_msg: got %h want %h", obs_full(), exp_full); end
        tick();
        exp_ctl = {1'b0, 2'd1, 8'h08};
        total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL xofflow_transfer: got %h want %h", obs_ctl(), exp_ctl); end
    endtask

    task automatic test_xoff_all();
        set_occ(3, 450);
        repeat (2) tick();
        exp_full = {1'b1, 16'd0, 16'hFFFF, 2'd2, 8'h08};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL xoffall_msg: got %h want %h", obs_full(), exp_full); end
        tick();
        set_occ(3, 350);
        exp_ctl = {1'b0, 2'd2, 8'h08};
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL xoffall_hold%0d: got %h want %h", i, obs_ctl(), exp_ctl); end
        end
        set_occ(3, 80);
        repeat (2) tick();
        exp_full = {1'b1, 16'd0, 16'd0, 2'd0, 8'h00};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL xoffall_to_xon_msg: got %h want %h", obs_full(), exp_full); end
        tick();
        exp_ctl = 11'd0;
        total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL xon_idle: got %h want %h", obs_ctl(), exp_ctl); end
    endtask

    task automatic test_multi_port();
        set_occ(1, 250); set_occ(6, 450);
        repeat (2) tick();
        exp_full = {1'b1, 16'd0, 16'hFFFF, 2'd2, 8'h42};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL multi_xoffall: got %h want %h", obs_full(), exp_full); end
        tick();
        set_occ(6, 250);
        repeat (2) tick();
        exp_full = {1'b1, 16'd5, 16'hFFFF, 2'd1, 8'h42};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL multi_down_to_low: got %h want %h", obs_full(), exp_full); end
        tick();
        en[1] = 1'b0; set_occ(6, 50);
        repeat (2) tick();
        exp_full = {1'b1, 16'd0, 16'd0, 2'd0, 8'h00};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL multi_disable_resume: got %h want %h", obs_full(), exp_full); end
        tick();
        set_occ(1, 0);
        tick();
        en = 8'hFF;
        repeat (2) tick();
        exp_ctl = 11'd0;
        total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL multi_reenable_quiet: got %h want %h", obs_ctl(), exp_ctl); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        set_occ(0, 250);
        tick();
        set_occ(0, 450);
        tick();
        exp_full = {1'b1, 16'd5, 16'hFFFF, 2'd1, 8'h01};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL b2b_first: got %h want %h", obs_full(), exp_full); end
        tick();
        exp_full = {1'b1, 16'd0, 16'hFFFF, 2'd2, 8'h01};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL b2b_coalesced: got %h want %h", obs_full(), exp_full); end
        repeat (2) tick();
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL b2b_stall_hold: got %h want %h", obs_full(), exp_full); end
        ready = 1'b1;
        exp_ctl = {1'b0, 2'd2, 8'h01};
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL b2b_single_transfer%0d: got %h want %h", i, obs_ctl(), exp_ctl); end
        end
        set_occ(0, 0);
        repeat (2) tick();
        exp_full = {1'b1, 16'd0, 16'd0, 2'd0, 8'h00};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL b2b_resume: got %h want %h", obs_full(), exp_full); end
        tick();
    endtask

    task automatic test_refresh();
        int gap;
        int seen;
        ready = 1'b1;
        set_occ(2, 250);
        repeat (2) tick();
        exp_full = {1'b1, 16'd5, 16'hFFFF, 2'd1, 8'h04};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL refresh_initial: got %h want %h", obs_full(), exp_full); end
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            while (gap < 40) begin
                tick();
                if (valid) break;
                gap++;
            end
            total++; if (gap !== 16) begin bad++; $display("FAIL refresh_gap%0d: got %0d want %0d", k, gap, 16); end
            total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL refresh_msg%0d: got %h want %h", k, obs_full(), exp_full); end
        end
        set_occ(2, 50);
        repeat (2) tick();
        exp_full = {1'b1, 16'd0, 16'd0, 2'd0, 8'h00};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL refresh_resume: got %h want %h", obs_full(), exp_full); end
        seen = 0;
        repeat (40) begin
            tick();
            if (valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL refresh_stopped: got %0d want %0d", seen, 0); end
    endtask

    task automatic test_reset_mid();
        int seen;
        ready = 1'b0;
        set_occ(4, 250);
        repeat (2) tick();
        exp_full = {1'b1, 16'd5, 16'hFFFF, 2'd1, 8'h10};
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL rst_pending: got %h want %h", obs_full(), exp_full); end
        #2 rstn = 1'b0;
        #1;
        exp_full = 43'd0;
        total++; if (obs_full() !== exp_full) begin bad++; $display("FAIL rst_async_clear: got %h want %h", obs_full(), exp_full); end
        set_occ(4, 0);
        ready = 1'b1;
        repeat (2) tick();
        #2 rstn = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_resume: got %0d want %0d", seen, 0); end
        exp_ctl = 11'd0;
        total++; if (obs_ctl() !== exp_ctl) begin bad++; $display("FAIL rst_idle_state: got %h want %h", obs_ctl(), exp_ctl); end
    endtask

    initial begin
        test_reset();
        test_xoff_low();
        test_xoff_all();
        test_multi_port();
        test_back_to_back();
        test_refresh();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
